ysyx_24080006_csr_wsched: RTL

YSYX_24080006_CSR_WSCHED -- requirements
Module: ysyx_24080006_csr_wsched

---
 rtl/ysyx_24080006_pkg.sv | 39 +++
 rtl/ysyx_24080006_csr_wsched.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ysyx_24080006_pkg.sv
// Shared CSR-side definitions for the ysyx_24080006 core.
// Holds the trap kind encoding, machine-mode CSR addresses, mstatus bit positions
// and the mstatus rewrite helpers used on trap entry and mret.
package ysyx_24080006_pkg;

  typedef enum logic {
    TrapEcall = 1'b0,
    TrapMret  = 1'b1
  } trap_kind_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;

  // Trap entry: stash MIE into MPIE, disable interrupts, record M-mode as previous.
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] m);
    logic [31:0] r;
    r                       = m;
    r[MSTATUS_MPIE]         = m[MSTATUS_MIE];
    r[MSTATUS_MIE]          = 1'b0;
    r[MSTATUS_MPP_LO+1 -: 2] = 2'b11;
    return r;
  endfunction

  // mret: restore MIE from MPIE, set MPIE, keep MPP at M-mode (only mode we support).
  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] m);
    logic [31:0] r;
    r                       = m;
    r[MSTATUS_MIE]          = m[MSTATUS_MPIE];
    r[MSTATUS_MPIE]         = 1'b1;
    r[MSTATUS_MPP_LO+1 -: 2] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/ysyx_24080006_csr_wsched.sv
// CSR write scheduler: serialises CSR-instruction writes and trap/mret mstatus
// bookkeeping onto the single CSR-file write port.
//
// Ports:
//   clock, reset                  - clock and synchronous active-low reset
//   ins_valid/ins_ready           - CSR-instruction write handshake (ins_waddr, ins_wdata)
//   trap_valid/trap_ready         - trap handshake (trap_kind, trap_pc, trap_cause)
//   mstatus_rdata                 - current mstatus, captured when a request is accepted
//   csr_we/csr_waddr/csr_wdata    - CSR-file write port
//   done                          - pulses on the last write of a request
//   busy                          - a request is in flight
module ysyx_24080006_csr_wsched
  import ysyx_24080006_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ins_valid,
  output logic        ins_ready,
  input  logic [11:0] ins_waddr,
  input  logic [31:0] ins_wdata,
  input  logic        trap_valid,
  output logic        trap_ready,
  input  logic        trap_kind,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] mstatus_rdata,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        done,
  output logic        busy
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StIns      = 3'd1,
    StTMepc    = 3'd2,
    StTMcause  = 3'd3,
    StTMstatus = 3'd4,
    StRMstatus = 3'd5
  } state_e;

  state_e      state_q;
  logic [11:0] ins_waddr_q;
  logic [31:0] ins_wdata_q;
  logic [31:2] trap_pc_q;    // mepc is word aligned, low bits never needed
  logic [31:0] trap_cause_q;
  logic [31:0] mstatus_q;

  logic        idle;
  logic        wr_we;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_done;

  assign idle = (state_q == StIdle);

  // Readies are held low while reset is asserted; traps take priority over instructions.
  assign trap_ready = reset & idle;
  assign ins_ready  = reset & idle & ~trap_valid;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StIdle;
      ins_waddr_q  <= '0;
      ins_wdata_q  <= '0;
      trap_pc_q    <= '0;
      trap_cause_q <= '0;
      mstatus_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (trap_valid) begin
            trap_pc_q    <= trap_pc[31:2];
            trap_cause_q <= trap_cause;
            mstatus_q    <= mstatus_rdata;
            state_q      <= (trap_kind == TrapMret) ? StRMstatus : StTMepc;
          end else if (ins_valid) begin
            ins_waddr_q <= ins_waddr;
            ins_wdata_q <= ins_wdata;
            mstatus_q   <= mstatus_rdata;
            state_q     <= StIns;
          end
        end
        StTMepc:    state_q <= StTMcause;
        StTMcause:  state_q <= StTMstatus;
        StIns,
        StTMstatus,
        StRMstatus: state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
    end
  end

  // Write port is decoded purely from registered state and latched payload.
  always_comb begin
    wr_we   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    wr_done = 1'b0;
    unique case (state_q)
      StIns: begin
        wr_we   = 1'b1;
        wr_addr = ins_waddr_q;
        wr_data = ins_wdata_q;
        wr_done = 1'b1;
      end
      StTMepc: begin
        wr_we   = 1'b1;
        wr_addr = CSR_MEPC;
        wr_data = {trap_pc_q, 2'b00};
      end
      StTMcause: begin
        wr_we   = 1'b1;
        wr_addr = CSR_MCAUSE;
        wr_data = trap_cause_q;
      end
      StTMstatus: begin
        wr_we   = 1'b1;
        wr_addr = CSR_MSTATUS;
        wr_data = mstatus_on_trap(mstatus_q);
        wr_done = 1'b1;
      end
      StRMstatus: begin
        wr_we   = 1'b1;
        wr_addr = CSR_MSTATUS;
        wr_data = mstatus_on_mret(mstatus_q);
        wr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset gating keeps the write port quiet even in the cycle reset is first applied.
  assign csr_we    = reset & wr_we;
  assign csr_waddr = reset ? wr_addr : '0;
  assign csr_wdata = reset ? wr_data : '0;
  assign done      = reset & wr_done;
  assign busy      = reset & ~idle;

endmodule
